// File: rtl/relu_seq_pkg.sv
// Shared types, geometry and the per-lane activation for the ReLU stream sequencer.
// Define LEAKY_RELU_EN to make negative lanes return in >>> 3 instead of zero.
package relu_seq_pkg;

  localparam int unsigned DATAW          = 8;
  localparam int unsigned LANES          = 4;
  localparam int unsigned MAXN           = 320;
  localparam int unsigned MAXD           = 3;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned ADDRW          = 17;
  localparam int unsigned LANE_BITS      = $clog2(LANES);
  localparam int unsigned TOTALW         = $clog2(MAXN * MAXN * MAXD + 1);

  typedef logic [LANES-1:0][DATAW-1:0] beat_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FINISH
  } state_t;

  typedef struct packed {
    logic  last;
    beat_t data;
  } fifo_entry_t;

  function automatic logic [DATAW-1:0] relu_lane(input logic [DATAW-1:0] x);
    logic [DATAW-1:0] y;
    if (x[DATAW-1]) begin
`ifdef LEAKY_RELU_EN
      y = $signed(x) >>> 3;
`else
      y = '0;
`endif
    end else begin
      y = x;
    end
    return y;
  endfunction

  function automatic beat_t relu_beat(input beat_t b);
    beat_t r;
    for (int l = 0; l < LANES; l++) begin
      r[l] = relu_lane(b[l]);
    end
    return r;
  endfunction

endpackage

// File: rtl/relu_skid_fifo.sv
// Result skid FIFO: holds activated beats plus a final-beat flag until the buffer accepts them.
// DEPTH must be a power of two so the pointers wrap naturally.
module relu_skid_fifo
  import relu_seq_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push_i,
  input  fifo_entry_t                  push_data_i,
  input  logic                         pop_i,
  output fifo_entry_t                  head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  fifo_entry_t     mem_q [DEPTH];
  logic [PTRW-1:0] wr_ptr_q;
  logic [PTRW-1:0] rd_ptr_q;
  logic [CNTW-1:0] count_q;

  // NOTE: storage has no reset; validity comes only from count_q, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + PTRW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PTRW'(1);
      end
      count_q <= count_q + CNTW'(push_i) - CNTW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/relu_stream_sequencer.sv
// Walks one feature map in LANES-wide beats: credit-limited reads, ReLU, skid FIFO, write-back.
// Element geometry (DATAW, LANES, ADDRW) comes from relu_seq_pkg.
module relu_stream_sequencer
  import relu_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [8:0]             cfg_width,
  input  logic [8:0]             cfg_height,
  input  logic [1:0]             cfg_depth,
  input  logic [ADDRW-1:0]       cfg_base,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_req,
  output logic [ADDRW-1:0]       rd_addr,
  input  logic                   rd_valid,
  input  logic [LANES*DATAW-1:0] rd_data,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [ADDRW-1:0]       wr_addr,
  output logic [LANES*DATAW-1:0] wr_data,
  output logic [LANES-1:0]       wr_strb
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  state_t               state_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 rd_req_q;
  logic [ADDRW-1:0]     base_q;
  logic [ADDRW-1:0]     beats_q;
  logic [ADDRW-1:0]     rd_idx_q;
  logic [ADDRW-1:0]     rx_idx_q;
  logic [ADDRW-1:0]     wr_idx_q;
  logic [LANE_BITS-1:0] last_lanes_q;
  logic [CW-1:0]        credit_q;
  logic [CW-1:0]        credit_d;
  logic [CW-1:0]        outst_q;

  logic [TOTALW-1:0]    cfg_total;
  logic [ADDRW-1:0]     cfg_beats;
  logic                 start_ok;
  logic                 rd_fire;
  logic                 rx_accept;
  logic                 wr_fire;
  logic                 last_rd;
  fifo_entry_t          push_entry;
  fifo_entry_t          head;
  logic [CW-1:0]        fifo_count;
  logic [LANES-1:0]     tail_strb;

  assign cfg_total = TOTALW'(cfg_width) * TOTALW'(cfg_height) * TOTALW'(cfg_depth);
  assign cfg_beats = ADDRW'(cfg_total >> LANE_BITS) + ADDRW'(|cfg_total[LANE_BITS-1:0]);

  assign start_ok  = start && (state_q == IDLE);
  assign rd_fire   = rd_req_q;
  // Responses with nothing outstanding belong to a pass abandoned by reset.
  assign rx_accept = rd_valid && (outst_q != '0);
  assign wr_fire   = wr_valid && wr_ready;
  assign last_rd   = (rd_idx_q == beats_q - ADDRW'(1));
  assign credit_d  = credit_q - CW'(rd_fire) + CW'(wr_fire);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_req_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (cfg_beats != '0) begin
              state_q  <= ISSUE;
              rd_req_q <= (credit_q != '0);
            end else begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (rd_fire && last_rd) begin
            state_q  <= DRAIN;
            rd_req_q <= 1'b0;
          end else begin
            rd_req_q <= (credit_d != '0);
          end
        end
        DRAIN: begin
          if (wr_fire && head.last) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_q       <= '0;
      beats_q      <= '0;
      last_lanes_q <= '0;
      rd_idx_q     <= '0;
      rx_idx_q     <= '0;
      wr_idx_q     <= '0;
      credit_q     <= CW'(FIFO_DEPTH);
      outst_q      <= '0;
    end else begin
      credit_q <= credit_d;
      outst_q  <= outst_q + CW'(rd_fire) - CW'(rx_accept);
      if (start_ok) begin
        base_q       <= cfg_base;
        beats_q      <= cfg_beats;
        last_lanes_q <= cfg_total[LANE_BITS-1:0];
        rd_idx_q     <= '0;
        rx_idx_q     <= '0;
        wr_idx_q     <= '0;
      end else begin
        if (rd_fire) begin
          rd_idx_q <= rd_idx_q + ADDRW'(1);
        end
        if (rx_accept) begin
          rx_idx_q <= rx_idx_q + ADDRW'(1);
        end
        if (wr_fire) begin
          wr_idx_q <= wr_idx_q + ADDRW'(1);
        end
      end
    end
  end

  assign push_entry = '{last: (rx_idx_q == beats_q - ADDRW'(1)), data: relu_beat(beat_t'(rd_data))};

  relu_skid_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (rx_accept),
    .push_data_i (push_entry),
    .pop_i       (wr_fire),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tail_strb = '0;
    for (int l = 0; l < LANES; l++) begin
      tail_strb[l] = (LANE_BITS'(l) < last_lanes_q);
    end
  end

  assign wr_valid = (fifo_count != '0);
  assign wr_data  = wr_valid ? head.data : '0;
  assign wr_strb  = !wr_valid ? '0 :
                    (head.last && (last_lanes_q != '0)) ? tail_strb : '1;
  assign wr_addr  = base_q + wr_idx_q;
  assign rd_addr  = base_q + rd_idx_q;
  assign rd_req   = rd_req_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_relu_stream_sequencer.sv
// Directed bench for relu_stream_sequencer: table of single-beat activations plus multi-beat,
// backpressure, zero-size, start-while-busy and reset-mid-pass sequences against a memory model.
`timescale 1ns/1ps
module tb_relu_stream_sequencer;
  import relu_seq_pkg::*;

  localparam int AW = ADDRW;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [8:0]    cfg_width;
  logic [8:0]    cfg_height;
  logic [1:0]    cfg_depth;
  logic [AW-1:0] cfg_base;
  logic          busy, done, rd_req, rd_valid, wr_valid, wr_ready;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [31:0]   rd_data, wr_data;
  logic [3:0]    wr_strb;

  relu_stream_sequencer dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .cfg_depth  (cfg_depth),
    .cfg_base   (cfg_base),
    .busy       (busy),
    .done       (done),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_strb    (wr_strb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    strb;
    int            cyc;
  } wr_rec_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_pend_t;

  typedef struct {
    logic [31:0] din;
    logic [31:0] relu;
    logic [31:0] leaky;
  } vec_t;

  logic [31:0]   mem [256];
  wr_rec_t       wr_log [$];
  rd_pend_t      pend [$];
  int            cyc, lat, bp_mode, last_rv_cyc;
  bit            chk_bp;
  int            n_checks, n_fail;
  int            done_cnt, req_cnt, wr_cnt;
  logic          prev_stall;
  logic [AW-1:0] prev_addr;
  logic [31:0]   prev_data;
  logic [3:0]    prev_strb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_lane(input logic [7:0] x);
    if (!x[7]) return x;
`ifdef LEAKY_RELU_EN
    return {{3{x[7]}}, x[7:3]};
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [31:0] exp_beat(input logic [31:0] b);
    logic [31:0] r;
    for (int l = 0; l < 4; l++) r[l*8 +: 8] = exp_lane(b[l*8 +: 8]);
    return r;
  endfunction

  // Memory responder, write monitor and invariant checks, all on the falling edge.
  initial begin
    rd_valid   = 1'b0;
    rd_data    = '0;
    wr_ready   = 1'b1;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      wr_ready = (bp_mode == 0) ? 1'b1 : ((cyc % 4) == 0);
      if (done) done_cnt++;
      if (wr_valid && wr_ready) begin
        wr_log.push_back('{wr_addr, wr_data, wr_strb, cyc});
        wr_cnt++;
      end
      if (chk_bp && prev_stall) begin
        check("stall_valid_held", wr_valid, 1'b1);
        check("stall_addr_held", wr_addr, prev_addr);
        check("stall_data_held", wr_data, prev_data);
        check("stall_strb_held", wr_strb, prev_strb);
      end
      prev_stall = wr_valid && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
      prev_strb  = wr_strb;
      if (rd_req) begin
        req_cnt++;
        pend.push_back('{mem[rd_addr[7:0]], cyc + lat});
      end
      if (chk_bp) check("credit_bound", (req_cnt - wr_cnt) <= 4, 1'b1);
      if (pend.size() != 0 && pend[0].due == cyc) begin
        rd_valid    = 1'b1;
        rd_data     = pend[0].data;
        last_rv_cyc = cyc;
        pend.delete(0);
      end else begin
        rd_valid = 1'b0;
        rd_data  = '0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_rd_req"}, rd_req, 1'b0);
    check({tag, "_wr_valid"}, wr_valid, 1'b0);
    check({tag, "_rd_addr"}, rd_addr, '0);
    check({tag, "_wr_addr"}, wr_addr, '0);
    check({tag, "_wr_data"}, wr_data, '0);
    check({tag, "_wr_strb"}, wr_strb, '0);
  endtask

  task automatic start_pass(input int w, input int h, input int d, input logic [AW-1:0] base);
    tick();
    start      = 1'b1;
    cfg_width  = 9'(w);
    cfg_height = 9'(h);
    cfg_depth  = 2'(d);
    cfg_base   = base;
    tick();
    start = 1'b0;
    check("first_rd_req", rd_req, 1'b1);
  endtask

  task automatic wait_done(input int d0, input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc; i++) begin
      if (done_cnt != d0) break;
      tick();
    end
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_busy_at_done"}, busy, 1'b1);
    tick();
    check({tag, "_done_low"}, done, 1'b0);
    check({tag, "_busy_low"}, busy, 1'b0);
  endtask

  task automatic fill(input logic [AW-1:0] base, input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = AW'(base + i);
      for (int l = 0; l < 4; l++) mem[a[7:0]][l*8 +: 8] = 8'(i * 37 + l * 91 + 5);
    end
  endtask

  task automatic verify_multi(input logic [AW-1:0] base, input int n, input int ll, input string tag);
    logic [AW-1:0] a;
    logic [3:0]    s;
    check({tag, "_write_count"}, wr_log.size(), n);
    for (int i = 0; i < n && i < wr_log.size(); i++) begin
      a = AW'(base + i);
      s = (i == n - 1 && ll != 0) ? 4'((1 << ll) - 1) : 4'hF;
      check($sformatf("%s_addr[%0d]", tag, i), wr_log[i].addr, a);
      check($sformatf("%s_data[%0d]", tag, i), wr_log[i].data, exp_beat(mem[a[7:0]]));
      check($sformatf("%s_strb[%0d]", tag, i), wr_log[i].strb, s);
    end
  endtask

  vec_t vecs [6];

  initial begin
    int d0, r0, ws;
    logic [AW-1:0] base;

    vecs[0] = '{32'hFB07807F, 32'h0007007F, 32'hFF07F07F};
    vecs[1] = '{32'hF0FF8003, 32'h00000003, 32'hFEFFF003};
    vecs[2] = '{32'h0001FF81, 32'h00010000, 32'h0001FFF0};
    vecs[3] = '{32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7F7F7F7F};
    vecs[4] = '{32'h80808080, 32'h00000000, 32'hF0F0F0F0};
    vecs[5] = '{32'hC040E818, 32'h00400018, 32'hF840FD18};

    n_checks = 0; n_fail = 0; done_cnt = 0; req_cnt = 0; wr_cnt = 0; cyc = 0;
    lat = 1; bp_mode = 0; chk_bp = 1'b0;
    rstn = 1'b0; start = 1'b0;
    cfg_width = '0; cfg_height = '0; cfg_depth = '0; cfg_base = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    repeat (2) tick();
    check_reset_outputs("reset");
    rstn = 1'b1;
    tick();

    // Single-beat activation table, W=2 H=2 D=1.
    for (int i = 0; i < 6; i++) begin
      base = AW'(17'h10 + 8 * i);
      mem[base[7:0]] = vecs[i].din;
      wr_log.delete();
      d0 = done_cnt;
      start_pass(2, 2, 1, base);
      wait_done(d0, 40, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_writes", i), wr_log.size(), 1);
      if (wr_log.size() != 0) begin
        check($sformatf("vec%0d_addr", i), wr_log[0].addr, base);
`ifdef LEAKY_RELU_EN
        check($sformatf("vec%0d_data", i), wr_log[0].data, vecs[i].leaky);
`else
        check($sformatf("vec%0d_data", i), wr_log[0].data, vecs[i].relu);
`endif
        check($sformatf("vec%0d_strb", i), wr_log[0].strb, 4'hF);
        if (i == 0) check("write_latency", wr_log[0].cyc, last_rv_cyc + 1);
      end
    end

    // Partial last beat, 9 elements, base wrapping through the top of the address space.
    lat = 2;
    base = 17'h1FFFE;
    fill(base, 3);
    wr_log.delete();
    d0 = done_cnt;
    start_pass(3, 1, 3, base);
    wait_done(d0, 60, "partial");
    verify_multi(base, 3, 1, "partial");

    // Zero size, then start held into the FINISH cycle.
    r0 = req_cnt;
    d0 = done_cnt;
    tick();
    start = 1'b1; cfg_width = 9'd5; cfg_height = 9'd5; cfg_depth = 2'd0; cfg_base = 17'h30;
    tick();
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b1);
    cfg_width = 9'd2; cfg_height = 9'd2; cfg_depth = 2'd1;
    tick();
    start = 1'b0;
    check("finish_start_ignored_busy", busy, 1'b0);
    check("finish_start_ignored_done", done, 1'b0);
    repeat (5) tick();
    check("zero_no_rd_req", req_cnt - r0, 0);
    check("zero_done_count", done_cnt - d0, 1);

    // Start pulse during a 12-beat pass must be ignored.
    fill(17'h40, 12);
    wr_log.delete();
    d0 = done_cnt;
    start_pass(4, 4, 3, 17'h40);
    repeat (3) tick();
    start = 1'b1; cfg_width = 9'd8; cfg_height = 9'd8; cfg_depth = 2'd1; cfg_base = 17'h80;
    tick();
    start = 1'b0;
    wait_done(d0, 300, "busy_start");
    verify_multi(17'h40, 12, 0, "busy_start");
    repeat (10) tick();
    check("busy_start_no_second_pass", done_cnt - d0, 1);

    // Backpressure: wr_ready 1 of 4 cycles, read latency 5.
    lat = 5;
    bp_mode = 1;
    chk_bp = 1'b1;
    fill(17'h20, 16);
    wr_log.delete();
    d0 = done_cnt;
    start_pass(8, 8, 1, 17'h20);
    wait_done(d0, 600, "bp");
    chk_bp = 1'b0;
    bp_mode = 0;
    verify_multi(17'h20, 16, 0, "bp");

    // Reset at beat 5 of 12 with reads in flight.
    fill(17'h60, 12);
    wr_log.delete();
    start_pass(4, 4, 3, 17'h60);
    for (int i = 0; i < 200 && wr_log.size() < 5; i++) tick();
    check("rst_reached_beat5", wr_log.size() >= 5, 1'b1);
    #1;
    rstn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    rstn = 1'b1;
    ws = wr_cnt;
    for (int i = 0; i < 40 && pend.size() != 0; i++) tick();
    repeat (3) tick();
    check("late_rv_no_write", wr_cnt - ws, 0);
    check("late_rv_idle", busy, 1'b0);
    wr_log.delete();
    d0 = done_cnt;
    start_pass(4, 4, 3, 17'h60);
    wait_done(d0, 300, "after_rst");
    verify_multi(17'h60, 12, 0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
